// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Mealy hold/bubble/flush controls; dmem freeze overrides everything.
module pipe_stall_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 stl_ctrl_clk,
  input  logic                 stl_ctrl_rst,
  input  logic                 ld_stall_req,
  input  logic                 br_flush_req,
  input  logic                 dmem_req_valid,
  input  logic                 dmem_rsp_ready,
  input  logic                 perf_clr,
  output logic                 pc_hold,
  output logic                 if_id_hold,
  output logic                 id_ex_hold,
  output logic                 ex_mem_hold,
  output logic                 mem_wb_bubble,
  output logic                 id_ex_bubble,
  output logic                 if_id_flush,
  output logic [1:0]           ctrl_state,
  output logic                 mem_timeout_err,
  output logic [CNT_WIDTH-1:0] stall_cycle_cnt
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FW-1:0] FRELOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FONE    = FW'(1);
  localparam logic [WW-1:0] WMAX    = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LD_BUBBLE = 2'd1,
    FLUSH     = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [FW-1:0]        flush_q, flush_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 freeze;

  assign freeze = dmem_req_valid & ~dmem_rsp_ready;

  always_ff @(posedge stl_ctrl_clk or negedge stl_ctrl_rst) begin
    if (!stl_ctrl_rst) begin
      state_q <= RUN;
      flush_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    if (!freeze) begin
      unique case (state_q)
        RUN, LD_BUBBLE: begin
          if (br_flush_req) begin
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              flush_d = FRELOAD;
            end else begin
              state_d = RUN;
            end
          end else if (ld_stall_req && state_q == RUN) begin
            state_d = LD_BUBBLE;
          end else begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          if (br_flush_req) begin
            flush_d = FRELOAD;
          end else if (flush_q == FONE) begin
            state_d = RUN;
            flush_d = '0;
          end else begin
            flush_d = flush_q - FONE;
          end
        end
        default: begin
          state_d = RUN;
          flush_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    if (stl_ctrl_rst) begin
      if (freeze) begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (br_flush_req) begin
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b1;
      end else if (state_q == RUN && ld_stall_req) begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (state_q == FLUSH) begin
        if_id_flush = 1'b1;
      end
    end
  end

  // Hang watchdog: counts consecutive freeze cycles, error is sticky.
  always_comb begin
    wait_d = '0;
    if (freeze) begin
      wait_d = (wait_q == WMAX) ? wait_q : wait_q + 1'b1;
    end
    err_d = err_q | (wait_d == WMAX);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (perf_clr) begin
      cnt_d = '0;
    end else if ((pc_hold | if_id_flush) && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign ctrl_state      = state_q;
  assign mem_timeout_err = err_q;
  assign stall_cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl.
// FLUSH_CYCLES=3, MEM_TIMEOUT=4, CNT_WIDTH=4.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld, br, dv, dr, clr;
  logic       pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic       mem_wb_bubble, id_ex_bubble, if_id_flush;
  logic [1:0] st;
  logic       err;
  logic [3:0] cnt;
  int         checks = 0;
  int         failures = 0;

  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_LD    = 7'b1100010;
  localparam logic [6:0] C_BR    = 7'b0000011;
  localparam logic [6:0] C_FL    = 7'b0000001;
  localparam logic [6:0] C_FRZ   = 7'b1111100;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .FLUSH_CYCLES(3),
    .MEM_TIMEOUT (4),
    .CNT_WIDTH   (4)
  ) dut (
    .stl_ctrl_clk   (clk),
    .stl_ctrl_rst   (rst_n),
    .ld_stall_req   (ld),
    .br_flush_req   (br),
    .dmem_req_valid (dv),
    .dmem_rsp_ready (dr),
    .perf_clr       (clr),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .id_ex_hold     (id_ex_hold),
    .ex_mem_hold    (ex_mem_hold),
    .mem_wb_bubble  (mem_wb_bubble),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .ctrl_state     (st),
    .mem_timeout_err(err),
    .stall_cycle_cnt(cnt)
  );

  function automatic logic [6:0] ctl();
    return {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
            mem_wb_bubble, id_ex_bubble, if_id_flush};
  endfunction

  task automatic cyc(input logic l, input logic b, input logic v,
                     input logic r, input logic c);
    @(negedge clk);
    ld = l; br = b; dv = v; dr = r; clr = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ld = 0; br = 0; dv = 0; dr = 0; clr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ld = 0; br = 0; dv = 0; dr = 0; clr = 0;
    #2;
    checks++;
    if ({ctl(), st, err, cnt} !== 14'd0) begin
      failures++;
      $display("FAIL reset_init got ctl=%b st=%0d err=%b cnt=%0d want 0",
               ctl(), st, err, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // reach count 5 while sitting in FLUSH
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (cnt !== 4'd5 || st !== 2'd2 || ctl() !== C_FL) begin
      failures++;
      $display("FAIL pre_reset got cnt=%0d st=%0d ctl=%b want 5 2 %b",
               cnt, st, ctl(), C_FL);
    end
    rst_n = 1'b0;
    br = 1'b1;
    ld = 1'b1;
    #1;
    checks++;
    if ({ctl(), st, err, cnt} !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset got ctl=%b st=%0d err=%b cnt=%0d want 0",
               ctl(), st, err, cnt);
    end
    @(negedge clk);
    ld = 0; br = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (ctl() !== C_LD || st !== 2'd0) begin
      failures++;
      $display("FAIL ld_c0 got ctl=%b st=%0d want %b 0", ctl(), st, C_LD);
    end
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (ctl() !== C_IDLE || st !== 2'd1) begin
      failures++;
      $display("FAIL ld_c1 got ctl=%b st=%0d want %b 1", ctl(), st, C_IDLE);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (ctl() !== C_IDLE || st !== 2'd0 || cnt !== 4'd1) begin
      failures++;
      $display("FAIL ld_c2 got ctl=%b st=%0d cnt=%0d want %b 0 1",
               ctl(), st, cnt, C_IDLE);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (ctl() !== C_BR || st !== 2'd0) begin
      failures++;
      $display("FAIL br_c0 got ctl=%b st=%0d want %b 0", ctl(), st, C_BR);
    end
    for (int i = 1; i <= 2; i++) begin
      cyc(1, 0, 0, 0, 0);
      checks++;
      if (ctl() !== C_FL || st !== 2'd2) begin
        failures++;
        $display("FAIL br_c%0d got ctl=%b st=%0d want %b 2",
                 i, ctl(), st, C_FL);
      end
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (ctl() !== C_IDLE || st !== 2'd0 || cnt !== 4'd3) begin
      failures++;
      $display("FAIL br_end got ctl=%b st=%0d cnt=%0d want %b 0 3",
               ctl(), st, cnt, C_IDLE);
    end
  endtask

  task automatic test_flush_freeze();
    do_reset();
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0);
      checks++;
      if (ctl() !== C_FRZ || st !== 2'd2) begin
        failures++;
        $display("FAIL ff_frz%0d got ctl=%b st=%0d want %b 2",
                 i, ctl(), st, C_FRZ);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (ctl() !== C_FL || st !== 2'd2) begin
        failures++;
        $display("FAIL ff_fl%0d got ctl=%b st=%0d want %b 2",
                 i, ctl(), st, C_FL);
      end
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (st !== 2'd0 || cnt !== 4'd6 || err !== 1'b0) begin
      failures++;
      $display("FAIL ff_end got st=%0d cnt=%0d err=%b want 0 6 0",
               st, cnt, err);
    end
  endtask

  task automatic test_flush_restart();
    do_reset();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (ctl() !== C_BR || st !== 2'd2) begin
      failures++;
      $display("FAIL rs_br got ctl=%b st=%0d want %b 2", ctl(), st, C_BR);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (ctl() !== C_FL || st !== 2'd2) begin
        failures++;
        $display("FAIL rs_fl%0d got ctl=%b st=%0d want %b 2",
                 i, ctl(), st, C_FL);
      end
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (st !== 2'd0 || ctl() !== C_IDLE) begin
      failures++;
      $display("FAIL rs_end got st=%0d ctl=%b want 0 %b", st, ctl(), C_IDLE);
    end
  endtask

  task automatic test_ld_bubble_branch();
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (ctl() !== C_BR || st !== 2'd1) begin
      failures++;
      $display("FAIL lb_br got ctl=%b st=%0d want %b 1", ctl(), st, C_BR);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (ctl() !== C_FL || st !== 2'd2) begin
      failures++;
      $display("FAIL lb_fl got ctl=%b st=%0d want %b 2", ctl(), st, C_FL);
    end
  endtask

  task automatic test_freeze_branch();
    do_reset();
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    checks++;
    if (ctl() !== C_FRZ || st !== 2'd0) begin
      failures++;
      $display("FAIL fb_frz got ctl=%b st=%0d want %b 0", ctl(), st, C_FRZ);
    end
    cyc(0, 1, 1, 1, 0);
    checks++;
    if (ctl() !== C_BR || st !== 2'd0) begin
      failures++;
      $display("FAIL fb_br got ctl=%b st=%0d want %b 0", ctl(), st, C_BR);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (st !== 2'd2) begin
      failures++;
      $display("FAIL fb_st got st=%0d want 2", st);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL to_early got err=%b want 0", err);
    end
    cyc(0, 0, 1, 1, 0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL to_set got err=%b want 1", err);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky got err=%b want 1", err);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    checks++;
    if (cnt !== 4'd15) begin
      failures++;
      $display("FAIL sat got cnt=%0d want 15", cnt);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (cnt !== 4'd0) begin
      failures++;
      $display("FAIL clr got cnt=%0d want 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_flush_freeze();
    test_flush_restart();
    test_ld_bubble_branch();
    test_freeze_branch();
    test_timeout();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall/flush sequencer for the 5-stage core: consumes the load-use stall request from the load hazard detector, the branch-taken flush request from EX and the data-memory handshake, and drives the per-stage hold/bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It arbitrates simultaneous requests, guarantees exactly one bubble per load-use hazard, stretches branch flushes over fetch latency, detects data-memory hangs, and counts lost cycles for performance monitoring.

## Interface
- FLUSH_CYCLES, 2, cycles if_id_flush is asserted per accepted branch flush (≥1)
- MEM_TIMEOUT, 16, consecutive freeze cycles that trigger mem_timeout_err (≥1)
- CNT_WIDTH, 32, width of stall_cycle_cnt
- Clock and reset: one clock, rising edge; reset is asynchronous and active-low.
- stl_ctrl_clk  in  1  clock
- stl_ctrl_rst  in  1  asynchronous active-low reset
- ld_stall_req  in  1  load-use hazard (combinational stall_en from hazard detector)
- br_flush_req  in  1  branch/jump taken, resolved in EX
- dmem_req_valid  in  1  MEM stage has a load/store outstanding
- dmem_rsp_ready  in  1  data memory completes the access this cycle
- perf_clr  in  1  synchronous clear of stall_cycle_cnt
- pc_hold  out  1  PC not updated
- if_id_hold  out  1  IF/ID register holds
- id_ex_hold  out  1  ID/EX register holds
- ex_mem_hold  out  1  EX/MEM register holds
- mem_wb_bubble  out  1  MEM/WB loads a NOP
- id_ex_bubble  out  1  ID/EX loads a NOP
- if_id_flush  out  1  IF/ID loads a NOP
- ctrl_state  out  2  FSM state: 0 RUN, 1 LD_BUBBLE, 2 FLUSH
- mem_timeout_err  out  1  sticky data-memory hang flag
- stall_cycle_cnt  out  CNT_WIDTH  saturating lost-cycle counter

## Operation
- freeze = dmem_req_valid & ~dmem_rsp_ready; highest priority in every state.
- Freeze: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_bubble = 1; id_ex_bubble, if_id_flush = 0; state and flush counter hold; all other requests ignored that cycle (they stay asserted because the pipeline is frozen).
- RUN, no freeze, br_flush_req=1: if_id_flush=1, id_ex_bubble=1, pc_hold=0 (PC takes target). Overrides ld_stall_req. If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1; else stay RUN.
- RUN, no freeze, ld_stall_req=1, br_flush_req=0: pc_hold=1, if_id_hold=1, id_ex_bubble=1; go to LD_BUBBLE.
- RUN, no request: all controls 0.
- LD_BUBBLE (one cycle): ld_stall_req ignored; br_flush_req handled as in RUN (including entry to FLUSH); otherwise all controls 0; go to RUN.
- FLUSH: if_id_flush=1; ld_stall_req ignored; flush_cnt decrements each non-freeze cycle; at flush_cnt=1 return to RUN. A new br_flush_req in FLUSH asserts id_ex_bubble and reloads flush_cnt=FLUSH_CYCLES-1.
- Timeout: wait_cnt increments each freeze cycle (saturating at MEM_TIMEOUT), clears on any non-freeze cycle; mem_timeout_err sets when wait_cnt reaches MEM_TIMEOUT; cleared only by reset.
- stall_cycle_cnt: +1 each cycle with pc_hold | if_id_flush; saturates at all-ones; perf_clr has priority (counter reads 0 the next cycle).

## Timing
- All hold/bubble/flush outputs are combinational (Mealy) from state and same-cycle inputs: zero-cycle latency from request to control.
- ctrl_state, flush_cnt, wait_cnt, mem_timeout_err, stall_cycle_cnt update on rising stl_ctrl_clk.
- Reset (asserted, including mid-operation): ctrl_state=0 (RUN), flush_cnt=0, wait_cnt=0, mem_timeout_err=0, stall_cycle_cnt=0; all control outputs forced 0 while reset is low.
- Load-use hazard costs exactly 1 cycle; branch flush costs FLUSH_CYCLES cycles plus any freeze cycles.
- Freeze ending with br_flush_req high: flush accepted in the first non-freeze cycle.

## Test plan
- Reset mid-FLUSH with stall_cycle_cnt=5 -> all outputs 0, ctrl_state=0 immediately; counter 0.
- ld_stall_req=1 held 2 cycles in RUN -> cycle 0: pc_hold=if_id_hold=id_ex_bubble=1; cycle 1: ctrl_state=1, all controls 0; cycle 2: RUN; stall_cycle_cnt=1.
- ld_stall_req=1 and br_flush_req=1 same cycle, FLUSH_CYCLES=2 -> if_id_flush=id_ex_bubble=1, pc_hold=0; next cycle ctrl_state=2, if_id_flush=1; then RUN; stall_cycle_cnt=2.
- FLUSH_CYCLES=3, freeze 3 cycles starting on the first FLUSH cycle -> freeze controls for 3 cycles, ctrl_state stays 2, then 2 more if_id_flush cycles before RUN.
- MEM_TIMEOUT=4, dmem_req_valid=1, dmem_rsp_ready=0 for 4 cycles -> mem_timeout_err=1 after the 4th edge, stays 1 after dmem_rsp_ready=1; 3-cycle freeze does not set it.
- CNT_WIDTH=4, 20 stall cycles -> counter stops at 15; perf_clr=1 with pc_hold=1 -> counter 0.
